// File: rtl/ctrl_edicion_reloj_if.sv
// Button/handshake bundle between the debouncers, the edit controller and the
// register-bank enable logic. The slave side is the edit controller.
interface ctrl_edicion_reloj_if #(
   parameter int P = 2
);
   logic         btn_prog;
   logic         btn_func;
   logic         btn_izq;
   logic         btn_der;
   logic         btn_arriba;
   logic         btn_abajo;
   logic         wr_ack;
   logic         f1;
   logic         f2;
   logic         f3;
   logic [P-1:0] posicion;
   logic         incr;
   logic         decr;
   logic         modo_prog;
   logic         wr_req;

   // wr_req/wr_ack: wr_req rises on leaving EDICION and holds until the edge
   // that samples wr_ack = 1; the transfer completes on that edge (same-cycle
   // ack is legal, so wr_req can be a single cycle wide).
   modport master (
      output btn_prog, btn_func, btn_izq, btn_der, btn_arriba, btn_abajo, wr_ack,
      input  f1, f2, f3, posicion, incr, decr, modo_prog, wr_req
   );

   modport slave (
      input  btn_prog, btn_func, btn_izq, btn_der, btn_arriba, btn_abajo, wr_ack,
      output f1, f2, f3, posicion, incr, decr, modo_prog, wr_req
   );
endinterface

// File: rtl/ctrl_edicion_reloj.sv
// Edit-mode controller: button edges -> function select, field position and
// inc/dec pulses; on leaving edit mode it requests an RTC write-back.
module ctrl_edicion_reloj #(
   parameter int P    = 2,
   parameter int TOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   ctrl_edicion_reloj_if.slave   bus,
   output logic [1:0]            estado_dbg
);
   localparam int            CW    = $clog2(TOUT + 1);
   localparam logic [CW-1:0] TLAST = CW'(TOUT - 1);

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      EDICION   = 2'd1,
      ESCRITURA = 2'd2
   } estado_t;

   estado_t       estado_q, estado_n;
   logic [5:0]    btn, btn_prev_q, btn_edge;
   logic [2:0]    fsel_q, fsel_n;
   logic [P-1:0]  pos_q, pos_n;
   logic          incr_q, incr_n;
   logic          decr_q, decr_n;
   logic          modo_q, wr_req_q;
   logic [CW-1:0] cnt_q, cnt_n;

   // Bit order doubles as the action priority: prog highest, abajo lowest.
   assign btn      = {bus.btn_prog, bus.btn_func, bus.btn_der,
                      bus.btn_izq, bus.btn_arriba, bus.btn_abajo};
   assign btn_edge = btn & ~btn_prev_q;

   always_comb begin
      estado_n = estado_q;
      fsel_n   = fsel_q;
      pos_n    = pos_q;
      incr_n   = 1'b0;
      decr_n   = 1'b0;
      cnt_n    = cnt_q;
      case (estado_q)
         REPOSO: begin
            fsel_n = 3'b000;
            pos_n  = '0;
            cnt_n  = '0;
            if (btn_edge[5]) begin
               estado_n = EDICION;
               fsel_n   = 3'b100;
            end
         end
         EDICION: begin
            cnt_n = '0;
            if (btn_edge[5]) begin
               estado_n = ESCRITURA;
            end else if (btn_edge[4]) begin
               fsel_n = {fsel_q[0], fsel_q[2:1]};
               pos_n  = '0;
            end else if (btn_edge[3]) begin
               pos_n = (pos_q == P'(2)) ? '0 : pos_q + P'(1);
            end else if (btn_edge[2]) begin
               pos_n = (pos_q == '0) ? P'(2) : pos_q - P'(1);
            end else if (btn_edge[1]) begin
               incr_n = 1'b1;
            end else if (btn_edge[0]) begin
               decr_n = 1'b1;
            end else if (cnt_q >= TLAST) begin
               // Idle for TOUT cycles: abandon the edit without a write-back.
               estado_n = REPOSO;
               fsel_n   = 3'b000;
               pos_n    = '0;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         ESCRITURA: begin
            if (bus.wr_ack) begin
               estado_n = REPOSO;
               fsel_n   = 3'b000;
               pos_n    = '0;
            end
         end
         default: begin
            estado_n = REPOSO;
            fsel_n   = 3'b000;
            pos_n    = '0;
            cnt_n    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q   <= REPOSO;
         btn_prev_q <= '1;
         fsel_q     <= 3'b000;
         pos_q      <= '0;
         incr_q     <= 1'b0;
         decr_q     <= 1'b0;
         modo_q     <= 1'b0;
         wr_req_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         estado_q   <= estado_n;
         btn_prev_q <= btn;
         fsel_q     <= fsel_n;
         pos_q      <= pos_n;
         incr_q     <= incr_n;
         decr_q     <= decr_n;
         modo_q     <= (estado_n != REPOSO);
         wr_req_q   <= (estado_n == ESCRITURA);
         cnt_q      <= cnt_n;
      end
   end

   assign bus.f1        = fsel_q[2];
   assign bus.f2        = fsel_q[1];
   assign bus.f3        = fsel_q[0];
   assign bus.posicion  = pos_q;
   assign bus.incr      = incr_q;
   assign bus.decr      = decr_q;
   assign bus.modo_prog = modo_q;
   assign bus.wr_req    = wr_req_q;
   assign estado_dbg    = estado_q;
endmodule

// File: tb/tb_ctrl_edicion_reloj.sv
// Directed bench: main instance (TOUT = 255) for editing and write-back,
// second instance (TOUT = 4) for the inactivity timeout.
module tb_ctrl_edicion_reloj;
   logic       clk;
   logic       reset;
   logic [1:0] estado_a, estado_t;
   int         n_checks;
   int         n_fail;
   int         n_incr;

   ctrl_edicion_reloj_if #(.P(2)) if_a ();
   ctrl_edicion_reloj_if #(.P(2)) if_t ();

   ctrl_edicion_reloj #(.P(2), .TOUT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (if_a),
      .estado_dbg (estado_a)
   );

   ctrl_edicion_reloj #(.P(2), .TOUT(4)) dut_t (
      .clk        (clk),
      .reset      (reset),
      .bus        (if_t),
      .estado_dbg (estado_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Order: {prog, func, der, izq, arriba, abajo}
   task automatic drive_a(input logic [5:0] v);
      if_a.btn_prog   = v[5];
      if_a.btn_func   = v[4];
      if_a.btn_der    = v[3];
      if_a.btn_izq    = v[2];
      if_a.btn_arriba = v[1];
      if_a.btn_abajo  = v[0];
   endtask

   task automatic drive_t(input logic [5:0] v);
      if_t.btn_prog   = v[5];
      if_t.btn_func   = v[4];
      if_t.btn_der    = v[3];
      if_t.btn_izq    = v[2];
      if_t.btn_arriba = v[1];
      if_t.btn_abajo  = v[0];
   endtask

   function automatic logic [2:0] fsel_a();
      return {if_a.f1, if_a.f2, if_a.f3};
   endfunction

   initial begin
      n_checks = 0;
      n_fail   = 0;
      drive_a(6'b100000);
      drive_t(6'b000000);
      if_a.wr_ack = 1'b0;
      if_t.wr_ack = 1'b0;

      // Reset with btn_prog held: no entry while it stays high
      reset = 1'b1;
      repeat (3) step();
      check_eq("rst_modo", if_a.modo_prog, 1'b0);
      check_eq("rst_fsel", fsel_a(), 3'b000);
      check_eq("rst_pos", if_a.posicion, 2'd0);
      check_eq("rst_wrreq", if_a.wr_req, 1'b0);
      check_eq("rst_incdec", {if_a.incr, if_a.decr}, 2'b00);
      reset = 1'b0;
      repeat (3) step();
      check_eq("hold_no_entry", if_a.modo_prog, 1'b0);
      check_eq("hold_estado", estado_a, 2'd0);

      // Release then press: entry one edge after the press
      drive_a(6'b000000);
      step();
      drive_a(6'b100000);
      step();
      check_eq("entry_modo", if_a.modo_prog, 1'b1);
      check_eq("entry_fsel", fsel_a(), 3'b100);
      check_eq("entry_pos", if_a.posicion, 2'd0);
      check_eq("entry_estado", estado_a, 2'd1);
      drive_a(6'b000000);
      step();

      // der x3 wraps 1,2,0; izq wraps 0->2; func rotates and clears position
      drive_a(6'b001000); step(); check_eq("der1", if_a.posicion, 2'd1);
      drive_a(6'b000000); step(); check_eq("der1_hold", if_a.posicion, 2'd1);
      drive_a(6'b001000); step(); check_eq("der2", if_a.posicion, 2'd2);
      drive_a(6'b000000); step();
      drive_a(6'b001000); step(); check_eq("der3_wrap", if_a.posicion, 2'd0);
      drive_a(6'b000000); step();
      drive_a(6'b000100); step(); check_eq("izq_wrap", if_a.posicion, 2'd2);
      drive_a(6'b000000); step();
      drive_a(6'b010000); step();
      check_eq("func_fsel", fsel_a(), 3'b010);
      check_eq("func_pos", if_a.posicion, 2'd0);
      drive_a(6'b000000); step();

      // Hold arriba 10 cycles: a single one-cycle incr pulse
      n_incr = 0;
      drive_a(6'b000010);
      for (int i = 0; i < 10; i++) begin
         step();
         n_incr += int'(if_a.incr);
         if (i == 0) check_eq("arriba_pulse", if_a.incr, 1'b1);
         if (i == 1) check_eq("arriba_width", if_a.incr, 1'b0);
      end
      check_eq("arriba_count", n_incr, 1);
      drive_a(6'b000000); step();

      // arriba and abajo together: arriba wins
      drive_a(6'b000011); step();
      check_eq("both_incdec", {if_a.incr, if_a.decr}, 2'b10);
      drive_a(6'b000000); step();
      check_eq("both_after", {if_a.incr, if_a.decr}, 2'b00);
      drive_a(6'b000001); step();
      check_eq("abajo_pulse", {if_a.incr, if_a.decr}, 2'b01);
      drive_a(6'b000000); step();

      // Position to 1, then prog+der together: write-back, position unchanged
      drive_a(6'b001000); step();
      drive_a(6'b000000); step();
      drive_a(6'b101000); step();
      check_eq("prog_wrreq", if_a.wr_req, 1'b1);
      check_eq("prog_modo", if_a.modo_prog, 1'b1);
      check_eq("prog_pos", if_a.posicion, 2'd1);
      check_eq("prog_fsel", fsel_a(), 3'b010);
      drive_a(6'b000000);

      // No ack for 5 cycles; a func press meanwhile is ignored
      for (int i = 0; i < 5; i++) begin
         drive_a((i == 2) ? 6'b010000 : 6'b000000);
         step();
         check_eq("wait_ack_wrreq", if_a.wr_req, 1'b1);
      end
      check_eq("escr_fsel_hold", fsel_a(), 3'b010);
      drive_a(6'b000000);
      if_a.wr_ack = 1'b1;
      step();
      check_eq("ack_wrreq", if_a.wr_req, 1'b0);
      check_eq("ack_modo", if_a.modo_prog, 1'b0);
      check_eq("ack_fsel", fsel_a(), 3'b000);
      check_eq("ack_pos", if_a.posicion, 2'd0);
      check_eq("ack_estado", estado_a, 2'd0);
      step();
      check_eq("stray_ack", {if_a.modo_prog, if_a.wr_req}, 2'b00);
      if_a.wr_ack = 1'b0;
      drive_a(6'b001000); step();
      check_eq("reposo_der_ignored", if_a.posicion, 2'd0);
      drive_a(6'b000000); step();

      // Timeout instance: idle exit exactly 4 edges after entry
      drive_t(6'b100000); step();
      check_eq("t_entry", if_t.modo_prog, 1'b1);
      drive_t(6'b000000);
      for (int i = 1; i <= 4; i++) begin
         step();
         check_eq("t_idle_modo", if_t.modo_prog, (i < 4) ? 1'b1 : 1'b0);
         check_eq("t_idle_wrreq", if_t.wr_req, 1'b0);
      end
      // der at edge 3 restarts the window: exit at edge 7
      drive_t(6'b100000); step();
      check_eq("t2_entry", if_t.modo_prog, 1'b1);
      drive_t(6'b000000);
      for (int i = 1; i <= 7; i++) begin
         drive_t((i == 3) ? 6'b001000 : 6'b000000);
         step();
         if (i == 3) check_eq("t2_der_pos", if_t.posicion, 2'd1);
         check_eq("t2_modo", if_t.modo_prog, (i < 7) ? 1'b1 : 1'b0);
         check_eq("t2_wrreq", if_t.wr_req, 1'b0);
      end
      drive_t(6'b000000);

      // Reset during ESCRITURA drops the request; a later ack does nothing
      drive_a(6'b100000); step();
      drive_a(6'b000000); step();
      drive_a(6'b100000); step();
      check_eq("pre_rst_wrreq", if_a.wr_req, 1'b1);
      drive_a(6'b000000);
      reset = 1'b1;
      step();
      check_eq("mid_rst_wrreq", if_a.wr_req, 1'b0);
      check_eq("mid_rst_modo", if_a.modo_prog, 1'b0);
      check_eq("mid_rst_fsel", fsel_a(), 3'b000);
      check_eq("mid_rst_estado", estado_a, 2'd0);
      reset = 1'b0;
      if_a.wr_ack = 1'b1;
      step();
      check_eq("late_ack", {if_a.modo_prog, if_a.wr_req}, 2'b00);
      if_a.wr_ack = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
